// File: rtl/random_arrow_gen.sv
// Pseudo-random arrow picker for the step sequencer: XNOR Fibonacci LFSR plus
// rejection sampling into [0, NUM_ARROWS-1], with valid/ready on both sides.
module random_arrow_gen #(
  parameter int              WIDTH      = 6,
  parameter logic [WIDTH-1:0] TAP_MASK  = 6'b110000,
  parameter logic [WIDTH-1:0] RESET_SEED = 6'b000001,
  parameter int              NUM_ARROWS = 5,
  parameter int              MAX_TRIES  = 8,
  parameter bit              NO_REPEAT  = 1'b0,
  parameter bit              FREE_RUN   = 1'b1,
  localparam int             K          = (NUM_ARROWS > 1) ? $clog2(NUM_ARROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_load,
  input  logic [WIDTH-1:0]      seed,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  arrow_valid,
  input  logic                  arrow_ready,
  output logic [K-1:0]          arrow_idx,
  output logic [NUM_ARROWS-1:0] arrow_onehot,
  output logic                  arrow_fallback,
  output logic [WIDTH-1:0]      rng_state
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [K:0]       NUM_K1   = (K+1)'(NUM_ARROWS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GEN  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [TRY_W-1:0] tries;
  logic [K-1:0]     last;
  logic             have_last;
  logic [K-1:0]     cand;
  logic             cand_ok;
  logic [K:0]       last_inc;
  logic [K-1:0]     fallback_idx;
  logic [WIDTH-1:0] seed_safe;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic fb;
    fb = ~^(s & TAP_MASK);
    return {s[WIDTH-2:0], fb};
  endfunction

  function automatic logic [NUM_ARROWS-1:0] onehot_of(input logic [K-1:0] idx);
    return NUM_ARROWS'(1) << idx;
  endfunction

  assign lfsr_nxt = lfsr_step(lfsr);
  assign cand     = lfsr_nxt[K-1:0];
  assign cand_ok  = ({1'b0, cand} < NUM_K1) && (!NO_REPEAT || !have_last || (cand != last));

  // Fallback walks to the neighbour of the last arrow so NO_REPEAT still holds.
  assign last_inc     = {1'b0, last} + (K+1)'(1);
  assign fallback_idx = !have_last ? '0 : ((last_inc == NUM_K1) ? '0 : last_inc[K-1:0]);

  // All-ones is the XNOR lockup state; knock bit0 down so it can never be loaded.
  assign seed_safe = (seed == '1) ? {seed[WIDTH-1:1], 1'b0} : seed;

  assign req_ready = (state == IDLE);
  assign rng_state = lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      lfsr           <= RESET_SEED;
      tries          <= '0;
      last           <= '0;
      have_last      <= 1'b0;
      arrow_valid    <= 1'b0;
      arrow_idx      <= '0;
      arrow_onehot   <= '0;
      arrow_fallback <= 1'b0;
    end else if (seed_load) begin
      lfsr         <= seed_safe;
      state        <= IDLE;
      arrow_valid  <= 1'b0;
      arrow_onehot <= '0;
      have_last    <= 1'b0;
      tries        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (FREE_RUN) lfsr <= lfsr_nxt;
          if (req_valid) begin
            state <= GEN;
            tries <= '0;
          end
        end
        GEN: begin
          lfsr <= lfsr_nxt;
          if (cand_ok) begin
            arrow_idx      <= cand;
            arrow_onehot   <= onehot_of(cand);
            arrow_fallback <= 1'b0;
            arrow_valid    <= 1'b1;
            state          <= OUT;
          end else if (tries == LAST_TRY) begin
            arrow_idx      <= fallback_idx;
            arrow_onehot   <= onehot_of(fallback_idx);
            arrow_fallback <= 1'b1;
            arrow_valid    <= 1'b1;
            state          <= OUT;
          end else begin
            tries <= tries + TRY_W'(1);
          end
        end
        OUT: begin
          if (arrow_ready) begin
            last         <= arrow_idx;
            have_last    <= 1'b1;
            arrow_valid  <= 1'b0;
            arrow_onehot <= '0;
            state        <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          arrow_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_arrow_gen.sv
// Directed bench for random_arrow_gen: default, NO_REPEAT and FREE_RUN builds.
module tb_random_arrow_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two FREE_RUN=0 builds
  logic       rst_n, seed_load, req_valid, arrow_ready;
  logic [5:0] seed;
  logic       a_req_ready, a_valid, a_fb, b_req_ready, b_valid, b_fb;
  logic [2:0] a_idx, b_idx;
  logic [4:0] a_oh, b_oh;
  logic [5:0] a_rng, b_rng;

  // FREE_RUN build has its own controls
  logic       fr_rst_n, fr_seed_load, fr_req_valid, fr_arrow_ready;
  logic [5:0] fr_seed;
  logic       fr_req_ready, fr_valid, fr_fb;
  logic [2:0] fr_idx;
  logic [4:0] fr_oh;
  logic [5:0] fr_rng;

  random_arrow_gen #(.NO_REPEAT(1'b0), .FREE_RUN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .req_valid(req_valid), .req_ready(a_req_ready), .arrow_valid(a_valid),
    .arrow_ready(arrow_ready), .arrow_idx(a_idx), .arrow_onehot(a_oh),
    .arrow_fallback(a_fb), .rng_state(a_rng));

  random_arrow_gen #(.NO_REPEAT(1'b1), .FREE_RUN(1'b0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .req_valid(req_valid), .req_ready(b_req_ready), .arrow_valid(b_valid),
    .arrow_ready(arrow_ready), .arrow_idx(b_idx), .arrow_onehot(b_oh),
    .arrow_fallback(b_fb), .rng_state(b_rng));

  random_arrow_gen #(.NO_REPEAT(1'b0), .FREE_RUN(1'b1)) dut_fr (
    .clk(clk), .rst_n(fr_rst_n), .seed_load(fr_seed_load), .seed(fr_seed),
    .req_valid(fr_req_valid), .req_ready(fr_req_ready), .arrow_valid(fr_valid),
    .arrow_ready(fr_arrow_ready), .arrow_idx(fr_idx), .arrow_onehot(fr_oh),
    .arrow_fallback(fr_fb), .rng_state(fr_rng));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] seed;
    logic [5:0] exp_load;
    logic [2:0] exp_idx;
    logic [4:0] exp_oh;
    logic [5:0] exp_rng;
    int         exp_lat;
  } vec_t;
  vec_t vecs[6];

  int         lat_a, lat_b;
  logic [2:0] cap_idx_a, cap_idx_b;
  logic [4:0] cap_oh_a, cap_oh_b;
  logic       cap_fb_a, cap_fb_b;
  logic [5:0] cap_rng_a, cap_rng_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and record when/what each FREE_RUN=0 build delivers.
  task automatic do_req(input int budget);
    lat_a = 0;
    lat_b = 0;
    req_valid = 1'b1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      req_valid = 1'b0;
      if (lat_a == 0 && a_valid) begin
        lat_a = n; cap_idx_a = a_idx; cap_oh_a = a_oh; cap_fb_a = a_fb; cap_rng_a = a_rng;
      end
      if (lat_b == 0 && b_valid) begin
        lat_b = n; cap_idx_b = b_idx; cap_oh_b = b_oh; cap_fb_b = b_fb; cap_rng_b = b_rng;
      end
      if (lat_a != 0 && lat_b != 0) break;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{6'b111111, 6'b111110, 3'd3, 5'b01000, 6'b111011, 3};
    vecs[1] = '{6'b000001, 6'b000001, 3'd3, 5'b01000, 6'b000011, 2};
    vecs[2] = '{6'b000000, 6'b000000, 3'd1, 5'b00010, 6'b000001, 2};
    vecs[3] = '{6'b100000, 6'b100000, 3'd0, 5'b00001, 6'b000000, 2};
    vecs[4] = '{6'b010010, 6'b010010, 3'd4, 5'b10000, 6'b100100, 2};
    vecs[5] = '{6'b000010, 6'b000010, 3'd3, 5'b01000, 6'b001011, 3};

    rst_n = 1'b0; seed_load = 1'b0; seed = '0; req_valid = 1'b0; arrow_ready = 1'b1;
    fr_rst_n = 1'b0; fr_seed_load = 1'b0; fr_seed = '0; fr_req_valid = 1'b0; fr_arrow_ready = 1'b0;
    tick(); tick();

    chk("reset req_ready", a_req_ready, 1);
    chk("reset arrow_valid", a_valid, 0);
    chk("reset arrow_idx", a_idx, 0);
    chk("reset arrow_onehot", a_oh, 0);
    chk("reset arrow_fallback", a_fb, 0);
    chk("reset rng_state", a_rng, 6'b000001);
    rst_n = 1'b1;
    tick();
    chk("idle rng holds", a_rng, 6'b000001);

    // First request on both builds
    do_req(20);
    chk("t1 latency", lat_a, 2);
    chk("t1 idx", cap_idx_a, 3);
    chk("t1 onehot", cap_oh_a, 5'b01000);
    chk("t1 rng", cap_rng_a, 6'b000011);
    chk("t1 fallback", cap_fb_a, 0);
    chk("t1 nr idx", cap_idx_b, 3);
    chk("t1 nr latency", lat_b, 2);
    tick();
    chk("t1 valid drop", a_valid, 0);
    chk("t1 req_ready back", a_req_ready, 1);
    chk("t1 onehot clear", a_oh, 0);

    // Second request: repeat allowed vs forbidden
    do_req(20);
    chk("t2 latency", lat_a, 7);
    chk("t2 idx", cap_idx_a, 3);
    chk("t2 rng", cap_rng_a, 6'b111011);
    chk("t2 fallback", cap_fb_a, 0);
    chk("t3 latency", lat_b, 9);
    chk("t3 idx", cap_idx_b, 4);
    chk("t3 onehot", cap_oh_b, 5'b10000);
    chk("t3 fallback", cap_fb_b, 1);
    chk("t3 rng", cap_rng_b, 6'b101111);
    tick();
    chk("t3 nr idle", b_req_ready, 1);

    // Seed table
    for (int v = 0; v < 6; v++) begin
      seed = vecs[v].seed;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      chk($sformatf("vec%0d load rng", v), a_rng, vecs[v].exp_load);
      chk($sformatf("vec%0d load req_ready", v), a_req_ready, 1);
      do_req(20);
      chk($sformatf("vec%0d latency", v), lat_a, vecs[v].exp_lat);
      chk($sformatf("vec%0d idx", v), cap_idx_a, vecs[v].exp_idx);
      chk($sformatf("vec%0d onehot", v), cap_oh_a, vecs[v].exp_oh);
      chk($sformatf("vec%0d rng", v), cap_rng_a, vecs[v].exp_rng);
      chk($sformatf("vec%0d fallback", v), cap_fb_a, 0);
      tick();
      chk($sformatf("vec%0d valid drop", v), a_valid, 0);
    end

    // seed_load mid-GEN aborts the pending result
    seed = 6'b000011; seed_load = 1'b1; tick(); seed_load = 1'b0;
    req_valid = 1'b1; tick(); req_valid = 1'b0;
    tick();
    chk("abort in GEN", a_req_ready, 0);
    seed = 6'b000001; seed_load = 1'b1; tick(); seed_load = 1'b0;
    chk("abort valid", a_valid, 0);
    chk("abort req_ready", a_req_ready, 1);
    chk("abort rng", a_rng, 6'b000001);
    begin
      int seen_valid = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (a_valid) seen_valid++;
      end
      chk("abort never valid", seen_valid, 0);
      chk("abort rng idle", a_rng, 6'b000001);
    end

    // Backpressure in OUT
    arrow_ready = 1'b0;
    req_valid = 1'b1; tick(); req_valid = 1'b0;
    tick();
    chk("hold valid", a_valid, 1);
    chk("hold idx", a_idx, 3);
    for (int i = 0; i < 10; i++) begin
      req_valid = (i % 2 == 0);
      tick();
      chk($sformatf("hold%0d idx", i), a_idx, 3);
      chk($sformatf("hold%0d rng", i), a_rng, 6'b000011);
      chk($sformatf("hold%0d valid", i), a_valid, 1);
      chk($sformatf("hold%0d req_ready", i), a_req_ready, 0);
    end
    req_valid = 1'b0;
    arrow_ready = 1'b1;
    tick();
    chk("release valid", a_valid, 0);
    chk("release req_ready", a_req_ready, 1);
    chk("release onehot", a_oh, 0);
    tick();
    chk("release stays idle", a_req_ready, 1);

    // Free-running LFSR period and async reset mid-OUT
    fr_rst_n = 1'b1;
    begin
      int lock_hits = 0;
      int early_wrap = 0;
      for (int i = 1; i <= 63; i++) begin
        tick();
        if (fr_rng == 6'b111111) lock_hits++;
        if (i < 63 && fr_rng == 6'b000001) early_wrap++;
      end
      chk("fr period rng", fr_rng, 6'b000001);
      chk("fr lockup hits", lock_hits, 0);
      chk("fr early wrap", early_wrap, 0);
    end
    begin
      int fr_lat = 0;
      fr_req_valid = 1'b1;
      for (int n = 1; n <= 20; n++) begin
        tick();
        fr_req_valid = 1'b0;
        if (fr_valid) begin fr_lat = n; break; end
      end
      chk("fr latency", fr_lat, 7);
      chk("fr idx", fr_idx, 3);
      chk("fr rng", fr_rng, 6'b111011);
    end
    tick();
    #2;
    fr_rst_n = 1'b0;
    #1;
    chk("mid-OUT reset valid", fr_valid, 0);
    chk("mid-OUT reset idx", fr_idx, 0);
    chk("mid-OUT reset onehot", fr_oh, 0);
    chk("mid-OUT reset fallback", fr_fb, 0);
    chk("mid-OUT reset rng", fr_rng, 6'b000001);
    chk("mid-OUT reset req_ready", fr_req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
